// File: rtl/decode_stage.sv
// decode_stage
//   Registered multi-lane RV32IM decode stage between fetch and rename/issue.
//   Each accepted bundle of FETCH_WIDTH instructions is decoded lane by lane
//   into op, immediate, register specifiers and control flags. Lanes that
//   follow the first control-flow or illegal lane are squashed. The result
//   is held in an output register (OUT) backed by one skid register (SKID).
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   flush            : drop OUT, SKID and any bundle offered this cycle
//   in_valid/in_ready: input handshake; in_instrs lane k at [32k+31:32k]
//   in_lane_mask     : real fetched lanes; in_pc is the PC of lane 0
//   out_valid/out_ready: output handshake
//   out_pc, out_lane_valid, out_op, out_imm, out_rs1/rs2/rd : decoded bundle
//   out_is_br, out_is_jmp, out_rd_mem, out_wr_mem, out_wr_reg, out_illegal
//                    : per-lane flags
//   dec_count        : running count of delivered valid lanes (wraps)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The source holds its payload stable until that edge; ready
// never depends combinationally on valid (in_ready is a register equal to
// "SKID empty").
module decode_stage #(
  parameter int FETCH_WIDTH = 2,
  parameter int DBITS       = 32,
  parameter int INSTBITS    = 32,
  parameter int OPBITS      = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INSTBITS*FETCH_WIDTH-1:0] in_instrs,
  input  logic [FETCH_WIDTH-1:0]          in_lane_mask,
  input  logic [DBITS-1:0]                in_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DBITS-1:0]                out_pc,
  output logic [FETCH_WIDTH-1:0]          out_lane_valid,
  output logic [OPBITS*FETCH_WIDTH-1:0]   out_op,
  output logic [DBITS*FETCH_WIDTH-1:0]    out_imm,
  output logic [5*FETCH_WIDTH-1:0]        out_rs1,
  output logic [5*FETCH_WIDTH-1:0]        out_rs2,
  output logic [5*FETCH_WIDTH-1:0]        out_rd,
  output logic [FETCH_WIDTH-1:0]          out_is_br,
  output logic [FETCH_WIDTH-1:0]          out_is_jmp,
  output logic [FETCH_WIDTH-1:0]          out_rd_mem,
  output logic [FETCH_WIDTH-1:0]          out_wr_mem,
  output logic [FETCH_WIDTH-1:0]          out_wr_reg,
  output logic [FETCH_WIDTH-1:0]          out_illegal,
  output logic [31:0]                     dec_count
);

  typedef enum logic [OPBITS-1:0] {
    INVALID_I = 0,
    ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I, SRA_I, SRL_I, SLL_I, MUL_I,
    ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SRAI_I, SRLI_I, SLLI_I,
    LUI_I, AUIPC_I, LW_I, SW_I, JAL_I, JALR_I,
    BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I
  } instr_op_t;

  typedef struct packed {
    instr_op_t        op;
    logic [DBITS-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             is_br;
    logic             is_jmp;
    logic             rd_mem;
    logic             wr_mem;
    logic             wr_reg;
    logic             illegal;
  } lane_t;

  typedef struct packed {
    logic [DBITS-1:0]       pc;
    logic [FETCH_WIDTH-1:0] lane_valid;
    lane_t [FETCH_WIDTH-1:0] lanes;
  } bundle_t;

  function automatic lane_t decode_lane(input logic [INSTBITS-1:0] ins);
    lane_t     d;
    instr_op_t op;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    op = INVALID_I;
    case (ins[6:0])
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: op = ADD_I;   3'd1: op = SLL_I;  3'd2: op = SLT_I;  3'd3: op = SLTU_I;
            3'd4: op = XOR_I;   3'd5: op = SRL_I;  3'd6: op = OR_I;   default: op = AND_I;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'd0) op = SUB_I;
          else if (f3 == 3'd5) op = SRA_I;
        end else if (f7 == 7'b0000001 && f3 == 3'd0) begin
          op = MUL_I;
        end
      end
      7'b0010011: begin
        case (f3)
          3'd0: op = ADDI_I;  3'd2: op = SLTI_I;  3'd3: op = SLTIU_I;
          3'd4: op = XORI_I;  3'd6: op = ORI_I;   3'd7: op = ANDI_I;
          3'd1: if (f7 == 7'b0000000) op = SLLI_I;
          default: begin
            if (f7 == 7'b0000000)      op = SRLI_I;
            else if (f7 == 7'b0100000) op = SRAI_I;
          end
        endcase
      end
      7'b0110111: op = LUI_I;
      7'b0010111: op = AUIPC_I;
      7'b0000011: if (f3 == 3'd2) op = LW_I;
      7'b0100011: if (f3 == 3'd2) op = SW_I;
      7'b1101111: op = JAL_I;
      7'b1100111: if (f3 == 3'd0) op = JALR_I;
      7'b1100011: begin
        case (f3)
          3'd0: op = BEQ_I;  3'd1: op = BNE_I;  3'd4: op = BLT_I;
          3'd5: op = BGE_I;  3'd6: op = BLTU_I; 3'd7: op = BGEU_I;
          default: op = INVALID_I;
        endcase
      end
      default: op = INVALID_I;
    endcase

    d     = '0;
    d.op  = op;
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    case (op)
      ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SRAI_I, SRLI_I, SLLI_I,
      LW_I, JALR_I:
        d.imm = DBITS'($signed(ins[31:20]));
      SW_I:
        d.imm = DBITS'($signed({ins[31:25], ins[11:7]}));
      BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I:
        d.imm = DBITS'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      LUI_I, AUIPC_I:
        d.imm = DBITS'($signed({ins[31:12], 12'b0}));
      JAL_I:
        d.imm = DBITS'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default:
        d.imm = '0;
    endcase
    d.is_br   = (op inside {BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I});
    d.is_jmp  = (op == JAL_I) || (op == JALR_I);
    d.rd_mem  = (op == LW_I);
    d.wr_mem  = (op == SW_I);
    d.illegal = (op == INVALID_I);
    // Everything except stores, branches and illegal encodings writes rd;
    // x0 is never a real destination.
    d.wr_reg  = !(d.illegal || d.is_br || d.wr_mem) && (d.rd != 5'd0);
    return d;
  endfunction

  function automatic logic [31:0] popcount(input logic [FETCH_WIDTH-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  // Combinational decode of the incoming bundle, including squash.
  bundle_t dec_b;
  logic    blocked;
  always_comb begin
    dec_b    = '0;
    dec_b.pc = in_pc;
    blocked  = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      dec_b.lanes[k]      = decode_lane(in_instrs[INSTBITS*k +: INSTBITS]);
      dec_b.lane_valid[k] = in_lane_mask[k] && !blocked;
      // The redirecting/illegal lane itself stays valid; later ones die.
      if (in_lane_mask[k] && (dec_b.lanes[k].is_br || dec_b.lanes[k].is_jmp ||
                              dec_b.lanes[k].illegal))
        blocked = 1'b1;
    end
  end

  bundle_t     out_q, out_d, skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] count_q, count_d;
  logic        accept, drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    count_d      = count_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) begin
        count_d = count_q + popcount(out_q.lane_valid);
        if (skid_valid_q) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      // in_ready_q guarantees SKID is empty whenever we accept, so an
      // accept that coincides with a drain can always go straight to OUT.
      if (accept) begin
        if (!out_valid_q || drain) begin
          out_d       = dec_b;
          out_valid_d = 1'b1;
        end else begin
          skid_d       = dec_b;
          skid_valid_d = 1'b1;
        end
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      count_q      <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      count_q      <= count_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = out_q.pc;
  assign out_lane_valid = out_q.lane_valid;
  assign dec_count      = count_q;

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane_out
    assign out_op[OPBITS*k +: OPBITS] = out_q.lanes[k].op;
    assign out_imm[DBITS*k +: DBITS]  = out_q.lanes[k].imm;
    assign out_rs1[5*k +: 5]          = out_q.lanes[k].rs1;
    assign out_rs2[5*k +: 5]          = out_q.lanes[k].rs2;
    assign out_rd[5*k +: 5]           = out_q.lanes[k].rd;
    assign out_is_br[k]               = out_q.lanes[k].is_br;
    assign out_is_jmp[k]              = out_q.lanes[k].is_jmp;
    assign out_rd_mem[k]              = out_q.lanes[k].rd_mem;
    assign out_wr_mem[k]              = out_q.lanes[k].wr_mem;
    assign out_wr_reg[k]              = out_q.lanes[k].wr_reg;
    assign out_illegal[k]             = out_q.lanes[k].illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Bench for decode_stage with FETCH_WIDTH=2. A table of hand-decoded
//   RV32IM instructions supplies expected fields; accepted bundles are
//   pushed to an expected queue and compared when the stage delivers them.
module tb_decode_stage;
  localparam int FW = 2;
  localparam int NI = 14;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [32*FW-1:0] in_instrs;
  logic [FW-1:0] in_lane_mask;
  logic [31:0]   in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [FW-1:0] out_lane_valid;
  logic [6*FW-1:0]  out_op;
  logic [32*FW-1:0] out_imm;
  logic [5*FW-1:0]  out_rs1, out_rs2, out_rd;
  logic [FW-1:0] out_is_br, out_is_jmp, out_rd_mem, out_wr_mem, out_wr_reg, out_illegal;
  logic [31:0]   dec_count;

  decode_stage #(.FETCH_WIDTH(FW), .DBITS(32), .INSTBITS(32), .OPBITS(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instrs(in_instrs),
    .in_lane_mask(in_lane_mask), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_lane_valid(out_lane_valid), .out_op(out_op), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_is_br(out_is_br), .out_is_jmp(out_is_jmp), .out_rd_mem(out_rd_mem),
    .out_wr_mem(out_wr_mem), .out_wr_reg(out_wr_reg), .out_illegal(out_illegal),
    .dec_count(dec_count)
  );

  // Reference table. flags = {is_br, is_jmp, rd_mem, wr_mem, wr_reg, illegal}
  // op codes: 0 INVALID, 1 ADD, 2 SUB, 11 MUL, 12 ADDI, 21 LUI, 22 AUIPC,
  //           23 LW, 24 SW, 25 JAL, 26 JALR, 27 BEQ, 28 BNE
  logic [31:0] t_instr [NI] = '{32'h00500093, 32'h002081B3, 32'hFFC12283, 32'h0020A223,
                                32'h00000463, 32'hFFFFFFFF, 32'h00208033, 32'h010000EF,
                                32'h123452B7, 32'h40628233, 32'hFE209EE3, 32'h022083B3,
                                32'h00008067, 32'h00001117};
  logic [5:0]  t_op    [NI] = '{6'd12, 6'd1, 6'd23, 6'd24, 6'd27, 6'd0, 6'd1, 6'd25,
                                6'd21, 6'd2, 6'd28, 6'd11, 6'd26, 6'd22};
  logic [31:0] t_imm   [NI] = '{32'd5, 32'd0, 32'hFFFFFFFC, 32'd4, 32'd8, 32'd0, 32'd0, 32'd16,
                                32'h12345000, 32'd0, 32'hFFFFFFFC, 32'd0, 32'd0, 32'h00001000};
  logic [4:0]  t_rs1   [NI] = '{5'd0, 5'd1, 5'd2, 5'd1, 5'd0, 5'd31, 5'd1, 5'd0,
                                5'd8, 5'd5, 5'd1, 5'd1, 5'd1, 5'd0};
  logic [4:0]  t_rs2   [NI] = '{5'd5, 5'd2, 5'd28, 5'd2, 5'd0, 5'd31, 5'd2, 5'd16,
                                5'd3, 5'd6, 5'd2, 5'd2, 5'd0, 5'd0};
  logic [4:0]  t_rd    [NI] = '{5'd1, 5'd3, 5'd5, 5'd4, 5'd8, 5'd31, 5'd0, 5'd1,
                                5'd5, 5'd4, 5'd29, 5'd7, 5'd0, 5'd2};
  logic [5:0]  t_flags [NI] = '{6'b000010, 6'b000010, 6'b001010, 6'b000100, 6'b100000,
                                6'b000001, 6'b000000, 6'b010010, 6'b000010, 6'b000010,
                                6'b100000, 6'b000010, 6'b010000, 6'b000010};

  int n_checks = 0;
  int n_fail   = 0;
  logic [49:0] exp_q[$];   // {pc, lane_valid, idx1, idx0}
  logic [31:0] exp_count;
  bit          mon_en = 0;
  bit          rand_rdy = 0;
  int          cur_i0, cur_i1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_inputs(input int i0, input int i1, input logic [1:0] mask,
                            input logic [31:0] pc);
    cur_i0       = i0;
    cur_i1       = i1;
    in_instrs    = {t_instr[i1], t_instr[i0]};
    in_lane_mask = mask;
    in_pc        = pc;
  endtask

  task automatic send(input int i0, input int i1, input logic [1:0] mask,
                      input logic [31:0] pc);
    int guard = 0;
    set_inputs(i0, i1, mask, pc);
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("accept_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [1:0] squash_model(input int i0, input logic [1:0] mask);
    logic [1:0] lv;
    lv[0] = mask[0];
    lv[1] = mask[1] && !(mask[0] && (t_flags[i0][5] || t_flags[i0][4] || t_flags[i0][0]));
    return lv;
  endfunction

  // ---------------- scoreboard ----------------
  initial begin
    logic [49:0] e;
    logic [1:0]  lv;
    int          idx;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("dec_count", dec_count, exp_count);
        if (rst || flush) begin
          exp_q.delete();
          if (rst) exp_count = '0;
        end else begin
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("spurious_out", out_valid, 0);
            end else begin
              e  = exp_q.pop_front();
              lv = e[17:16];
              check("out_pc", out_pc, e[49:18]);
              check("lane_valid", out_lane_valid, lv);
              for (int k = 0; k < FW; k++) begin
                if (lv[k]) begin
                  idx = (k == 0) ? int'(e[7:0]) : int'(e[15:8]);
                  check($sformatf("lane%0d_op", k),  out_op[6*k +: 6],   t_op[idx]);
                  check($sformatf("lane%0d_imm", k), out_imm[32*k +: 32], t_imm[idx]);
                  check($sformatf("lane%0d_rs1", k), out_rs1[5*k +: 5],  t_rs1[idx]);
                  check($sformatf("lane%0d_rs2", k), out_rs2[5*k +: 5],  t_rs2[idx]);
                  check($sformatf("lane%0d_rd", k),  out_rd[5*k +: 5],   t_rd[idx]);
                  check($sformatf("lane%0d_flags", k),
                        {out_is_br[k], out_is_jmp[k], out_rd_mem[k], out_wr_mem[k],
                         out_wr_reg[k], out_illegal[k]}, t_flags[idx]);
                end
              end
              exp_count = exp_count + 32'(lv[0]) + 32'(lv[1]);
            end
          end
          if (in_valid && in_ready)
            exp_q.push_back({in_pc, squash_model(cur_i0, in_lane_mask),
                             8'(cur_i1), 8'(cur_i0)});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instrs = '0; in_lane_mask = '0; in_pc = '0;
    cur_i0 = 0; cur_i1 = 0; exp_count = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_dec_count", dec_count, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_imm", out_imm, 0);
    mon_en = 1;

    // Basic decode and one-cycle latency.
    out_ready = 1'b1;
    send(0, 1, 2'b11, 32'h0000_1000);
    check("basic_out_valid", out_valid, 1);
    check("basic_lane_valid", out_lane_valid, 2'b11);

    // Directed bundles; fields checked by the scoreboard.
    send(2, 3, 2'b11, 32'h0000_1008);   // LW / SW
    send(4, 0, 2'b11, 32'h0000_1010);   // BEQ squashes lane 1
    send(5, 1, 2'b11, 32'h0000_1018);   // illegal squashes lane 1
    send(6, 7, 2'b11, 32'h0000_1020);   // ADD x0 / JAL
    send(8, 9, 2'b10, 32'h0000_1028);   // lane 0 masked off
    send(10, 11, 2'b11, 32'h0000_1030); // BNE squashes MUL
    send(12, 13, 2'b11, 32'h0000_1038); // JALR squashes AUIPC
    send(11, 13, 2'b01, 32'h0000_1040); // lane 1 masked off
    send(13, 4, 2'b11, 32'h0000_1048);  // branch in last lane stays valid

    // Random traffic with random downstream stalls.
    rand_rdy = 1;
    for (int n = 0; n < 30; n++)
      send(int'($urandom_range(0, NI-1)), int'($urandom_range(0, NI-1)),
           2'($urandom_range(1, 3)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    rand_rdy = 0;
    out_ready = 1'b1;
    repeat (4) tick();

    // Backpressure: A in OUT, B in SKID, C held.
    out_ready = 1'b0;
    send(0, 1, 2'b11, 32'h0000_A000);
    send(2, 3, 2'b11, 32'h0000_B000);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    set_inputs(8, 9, 2'b11, 32'h0000_C000);
    in_valid = 1'b1;
    tick();
    tick();
    check("bp_c_held", in_ready, 0);
    check("bp_out_pc_a", out_pc, 32'h0000_A000);
    out_ready = 1'b1;
    tick();
    check("bp_out_valid_b", out_valid, 1);
    check("bp_out_pc_b", out_pc, 32'h0000_B000);
    check("bp_in_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_out_valid_c", out_valid, 1);
    check("bp_out_pc_c", out_pc, 32'h0000_C000);
    tick();
    check("bp_drained", out_valid, 0);

    // Flush with OUT and SKID full while D is offered.
    out_ready = 1'b0;
    send(0, 1, 2'b11, 32'h0000_D000);
    send(2, 3, 2'b11, 32'h0000_D008);
    set_inputs(8, 9, 2'b11, 32'h0000_D010);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_d_absent", out_valid, 0);

    // Mid-stream reset; dec_count is non-zero here from earlier traffic.
    out_ready = 1'b0;
    send(11, 13, 2'b11, 32'h0000_E000);
    send(1, 0, 2'b11, 32'h0000_E008);
    set_inputs(8, 9, 2'b11, 32'h0000_E010);
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_dec_count", dec_count, 0);
    check("rst2_out_imm", out_imm, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst2_d_absent", out_valid, 0);

    // One more bundle after reset to see the count restart from zero.
    send(0, 1, 2'b11, 32'h0000_F000);
    repeat (3) tick();
    check("final_dec_count", dec_count, 2);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, multi-lane decode stage between fetch and rename/issue. Each cycle it accepts a bundle of up to `FETCH_WIDTH` 32-bit RV32IM instructions. It decodes every lane in parallel into op, immediate, register specifiers and control flags. Decoded bundles leave through a valid/ready interface backed by a skid buffer. Lanes after the first control-flow or illegal instruction in a bundle are squashed. The stage supports a pipeline flush and keeps a running count of decoded instructions.

## Interface
- `FETCH_WIDTH`, 2, number of lanes per bundle (1..8).
- `DBITS`, 32, data/immediate/PC width.
- `INSTBITS`, 32, instruction width.
- `OPBITS`, 6, width of the `instr_op_t` encoding carried per lane.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: drop all buffered and incoming bundles.
- `in_valid` in 1: the input bundle is valid.
- `in_ready` out 1: the stage can accept a bundle.
- `in_instrs` in INSTBITS*FETCH_WIDTH: lane k occupies bits [INSTBITS*(k+1)-1 : INSTBITS*k].
- `in_lane_mask` in FETCH_WIDTH: which fetched lanes are real.
- `in_pc` in DBITS: PC of lane 0. Lane k's PC is `in_pc + 4k`.
- `out_valid` out 1: the output bundle is valid.
- `out_ready` in 1: downstream accepts the bundle.
- `out_pc` out DBITS: lane 0 PC of the bundle.
- `out_lane_valid` out FETCH_WIDTH: per-lane valid after squashing.
- `out_op` out OPBITS*FETCH_WIDTH: per-lane decoded op. Unrecognised encodings give INVALID_I.
- `out_imm` out DBITS*FETCH_WIDTH: per-lane sign-extended immediate.
- `out_rs1`, `out_rs2`, `out_rd` out 5*FETCH_WIDTH each: taken from instr[19:15], [24:20] and [11:7].
- `out_is_br`, `out_is_jmp`, `out_rd_mem`, `out_wr_mem`, `out_wr_reg`, `out_illegal` out FETCH_WIDTH each: per-lane flags.
- `dec_count` out 32: total number of lanes delivered with `out_lane_valid` set.

## Operation
- **Per-lane combinational decode.** The op set is R-type ADD/SUB/AND/OR/XOR/SLT/SLTU/SRA/SRL/SLL/MUL plus ADDI/ANDI/ORI/XORI/SLTI/SLTIU/SRAI/SRLI/SLLI, LUI, AUIPC, LW, SW, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
- **Immediates:**
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - All other ops: 0.
- **Flags:**
  - `is_br` is set for the 6 branches.
  - `is_jmp` is set for JAL and JALR.
  - `rd_mem` is set for LW; `wr_mem` is set for SW.
  - `wr_reg` is set for every rd-writing op, and only when rd≠0.
  - `illegal` is set when op = INVALID_I. An illegal lane forces all its other flags to 0.
- **Squash.** `lane_valid[k] = mask[k]` AND no lane j<k with `mask[j]` and (`is_br`|`is_jmp`|`illegal`). The control-flow or illegal lane itself stays valid.
- **Buffering.** There is one output register (OUT) and one skid register (SKID).
  - `in_ready` is a registered signal equal to "SKID empty".
  - Accept occurs when `in_valid && in_ready`.
  - When accepting, the decoded bundle goes to OUT if OUT is empty or is draining this cycle (`out_valid && out_ready`). Otherwise it goes to SKID.
  - When OUT drains and SKID is full, SKID moves into OUT.
  - Bundles are never reordered, duplicated or lost, except on flush.
- **Flush** has priority over everything else. Next cycle both entries are empty, `out_valid`=0 and `in_ready`=1. An input offered in the flush cycle is dropped. `dec_count` is not incremented for flushed bundles.
- **dec_count** adds popcount(`out_lane_valid`) on each `out_valid && out_ready`. It wraps modulo 2^32.
- **Data fields** are don't-care while `out_valid`=0. The implementation holds the last value.

## Timing
- Latency: a bundle accepted at edge N is visible on the outputs after edge N (`out_valid`=1 in cycle N+1) when OUT was empty.
- Throughput: one bundle per cycle while `out_ready`=1.
- Backpressure: `in_ready` deasserts on the cycle after SKID fills. SKID absorbs the one bundle accepted during the ready-deassertion latency.
- Simultaneous events:
  - Accept plus drain with SKID empty: OUT is replaced, SKID stays empty.
  - Accept plus drain with SKID full: not possible, because `in_ready`=0.
- Reset (synchronous, next edge): OUT and SKID are empty, `out_valid`=0, `in_ready`=1 and `dec_count`=0. All data outputs reset to 0. A mid-stream reset discards any in-flight bundles, exactly like flush.

## Test plan
- **Basic decode.** FETCH_WIDTH=2. Lane0=0x00500093 (ADDI x1,x0,5), lane1=0x002081B3 (ADD x3,x1,x2), mask=11. Required response:
  - One cycle later, `out_valid`=1 and `lane_valid`=11.
  - Lane0: imm=5, rd=1, `wr_reg`=1.
  - Lane1: rs1=1, rs2=2, rd=3, imm=0.
- **Memory immediates.** Lane0=0xFFC12283 (LW x5,-4(x2)) gives imm=0xFFFFFFFC and `rd_mem`=1. Lane1=0x0020A223 (SW x2,4(x1)) gives imm=4, `wr_mem`=1 and `wr_reg`=0.
- **Squash.** Lane0=0x00000463 (BEQ x0,x0,8), lane1=ADDI, mask=11. Required response:
  - `lane_valid`=01, lane0 imm=8, `is_br`=1.
  - `dec_count` rises by 1 when the bundle is taken.
- **Illegal and rd=0.**
  - Lane0=0xFFFFFFFF gives `illegal`=1, all other flags 0, and lane1 squashed.
  - ADD x0,x1,x2 (0x00208033) gives `wr_reg`=0.
- **Backpressure.** Hold `out_ready`=0 and drive 3 back-to-back bundles A, B, C. Required response:
  - A sits in OUT and B in SKID. `in_ready`=0 from the following cycle, so C is held.
  - Release `out_ready`: the outputs show A, B, C in order with no gaps.
- **Flush and reset.** Fill OUT and SKID, then pulse `flush` while presenting D. Next cycle `out_valid`=0, `in_ready`=1 and D is absent. Repeat with `rst`: `dec_count` additionally returns to 0.
